// File: rtl/dvp_pkg.sv
// Shared types and default geometry for the OV5640 DVP capture path.
package dvp_pkg;
  localparam int DEF_H_PIXEL     = 800;
  localparam int DEF_V_PIXEL     = 480;
  localparam int DEF_SKIP_FRAMES = 10;
  localparam int DEF_CNT_W       = 11;

  typedef enum logic [1:0] {WAIT_CFG, SKIP, RUN} state_t;
endpackage

// File: rtl/dvp_if.sv
// DVP sensor pins: the sensor drives (master), the capture block receives (slave).
interface dvp_if;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output vsync, href, data);
  modport slave  (input  vsync, href, data);
endinterface

// File: rtl/dvp_byte_pack.sv
// Input registers, edge detection and byte-pair assembly into 16-bit words.
module dvp_byte_pack (
  input  logic        clk,
  input  logic        rst,
  dvp_if.slave        dvp,
  output logic        v_rise,
  output logic        h_fall,
  output logic        pix_done,
  output logic [15:0] pix_word
);
  logic       v_d, h_d, v_q, h_q, phase;
  logic [7:0] d_d, hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_d   <= 1'b0;
      h_d   <= 1'b0;
      d_d   <= '0;
      v_q   <= 1'b0;
      h_q   <= 1'b0;
      phase <= 1'b0;
      hi    <= '0;
    end else begin
      v_d   <= dvp.vsync;
      h_d   <= dvp.href;
      d_d   <= dvp.data;
      v_q   <= v_d;
      h_q   <= h_d;
      phase <= h_d ? ~phase : 1'b0;
      if (h_d && !phase) hi <= d_d;
    end
  end

  // A pending high byte is simply abandoned when href drops; phase clears.
  assign v_rise   = v_d & ~v_q;
  assign h_fall   = h_q & ~h_d;
  assign pix_done = h_d & phase;
  assign pix_word = {hi, d_d};
endmodule

// File: rtl/dvp_capture.sv
// OV5640 DVP capture: frame skip FSM, x/y tagging and clipping to display geometry.
// Optional line/frame measurement and mismatch flag under `GEOM_CHECK_EN.
module dvp_capture
  import dvp_pkg::*;
#(
  parameter int H_PIXEL     = DEF_H_PIXEL,
  parameter int V_PIXEL     = DEF_V_PIXEL,
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             ov5640_pclk,
  input  logic             sys_rst,
  input  logic             cfg_done,
  dvp_if.slave             ov5640,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             frame_end,
  output logic             capture_on,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             err_geom
);
  localparam int              SK_W    = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_PIXEL);
  localparam logic [CNT_W-1:0] V_LIM   = CNT_W'(V_PIXEL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             v_rise, h_fall, pix_done;
  logic [15:0]      pix_word;
  logic [CNT_W-1:0] x_cnt, y_cnt, y_line;
  logic [SK_W-1:0]  skip_cnt, skip_inc;
  state_t           state;
  logic             run_next, in_frame;

  dvp_byte_pack u_pack (
    .clk      (ov5640_pclk),
    .rst      (sys_rst),
    .dvp      (ov5640),
    .v_rise   (v_rise),
    .h_fall   (h_fall),
    .pix_done (pix_done),
    .pix_word (pix_word)
  );

  // Line close is folded in before the frame clear, so a coincident
  // vsync rise still counts the line that just ended.
  assign y_line   = (h_fall && x_cnt != '0) ? sat_inc(y_cnt) : y_cnt;
  assign skip_inc = skip_cnt + 1'b1;
  assign in_frame = (state == RUN) && cfg_done && (x_cnt < H_LIM) && (y_cnt < V_LIM);

  always_comb begin
    run_next = (state == RUN);
    if (!cfg_done)                         run_next = 1'b0;
    else if (v_rise && state == WAIT_CFG)  run_next = (SKIP_FRAMES == 0);
    else if (v_rise && state == SKIP)      run_next = (skip_inc == SK_W'(SKIP_FRAMES));
  end

  always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (pix_done)    x_cnt <= sat_inc(x_cnt);
      else if (h_fall) x_cnt <= '0;
      y_cnt <= v_rise ? '0 : y_line;
    end
  end

  always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= WAIT_CFG;
      skip_cnt    <= '0;
      capture_on  <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      frame_end   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      if (!cfg_done) state <= WAIT_CFG;
      else if (v_rise) begin
        case (state)
          WAIT_CFG: begin
            skip_cnt <= '0;
            state    <= (SKIP_FRAMES == 0) ? RUN : SKIP;
          end
          SKIP: begin
            skip_cnt <= skip_inc;
            if (skip_inc == SK_W'(SKIP_FRAMES)) state <= RUN;
          end
          default: ;
        endcase
      end
      capture_on  <= run_next;
      frame_start <= v_rise && run_next;
      pix_valid   <= pix_done && in_frame;
      frame_end   <= pix_done && in_frame && x_cnt == H_LIM - 1'b1 && y_cnt == V_LIM - 1'b1;
      if (pix_done) begin
        pix_data <= pix_word;
        pix_x    <= x_cnt;
        pix_y    <= y_cnt;
      end
    end
  end

`ifdef GEOM_CHECK_EN
  always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      line_len    <= '0;
      frame_lines <= '0;
      err_geom    <= 1'b0;
    end else begin
      if (h_fall) line_len    <= x_cnt;
      if (v_rise) frame_lines <= y_line;
      if (!run_next)
        err_geom <= 1'b0;
      else if (state == RUN &&
               ((h_fall && x_cnt != '0 && x_cnt != H_LIM) || (v_rise && y_line != V_LIM)))
        err_geom <= 1'b1;
    end
  end
`else
  assign line_len    = '0;
  assign frame_lines = '0;
  assign err_geom    = 1'b0;
`endif
endmodule

// File: tb/tb_dvp_capture.sv
// Randomized and directed bench for dvp_capture against a pin-level behavioural model.
module tb_dvp_capture;
  localparam int H = 4, V = 2, SK = 2, CW = 11;
`ifdef GEOM_CHECK_EN
  localparam bit GEOM = 1'b1;
`else
  localparam bit GEOM = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, cfg = 1'b0;
  always #5 clk = ~clk;

  dvp_if ov();

  logic          pv, fs, fe, con, err;
  logic [15:0]   pd;
  logic [CW-1:0] px, py, ll, fl;

  dvp_capture #(.H_PIXEL(H), .V_PIXEL(V), .SKIP_FRAMES(SK), .CNT_W(CW)) dut (
    .ov5640_pclk (clk),
    .sys_rst     (rst),
    .cfg_done    (cfg),
    .ov5640      (ov),
    .pix_valid   (pv),
    .pix_data    (pd),
    .pix_x       (px),
    .pix_y       (py),
    .frame_start (fs),
    .frame_end   (fe),
    .capture_on  (con),
    .line_len    (ll),
    .frame_lines (fl),
    .err_geom    (err)
  );

  int tests = 0, fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for config, 1 skipping frames, 2 delivering
  int   mode, skip, x, y, run_len, m_ll, m_fl, om, nm;
  bit   m_err, vs1, vs2, hr1, hr2, vr, hf, done;
  logic [7:0] d1, d2;
  bit   e_pv, e_fs, e_fe, e_con;
  logic [15:0] e_pd;
  int   e_px, e_py;

  function automatic int sat(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = 0; skip = 0; x = 0; y = 0; run_len = 0; m_ll = 0; m_fl = 0; m_err = 0;
      vs1 = 0; vs2 = 0; hr1 = 0; hr2 = 0; d1 = 0; d2 = 0;
      e_pv = 0; e_fs = 0; e_fe = 0; e_con = 0; e_pd = 0; e_px = 0; e_py = 0;
    end else begin
      vr = vs1 && !vs2;
      hf = !hr1 && hr2;
      run_len = hr1 ? run_len + 1 : 0;
      done = hr1 && (run_len % 2 == 0);
      om = mode; nm = mode;
      if (!cfg) nm = 0;
      else if (vr) begin
        if (mode == 0) begin skip = 0; nm = (SK == 0) ? 2 : 1; end
        else if (mode == 1) begin skip++; if (skip == SK) nm = 2; end
      end
      e_pv = 0; e_fe = 0;
      e_fs = vr && nm == 2;
      e_con = (nm == 2);
      if (done) begin
        e_pv = (om == 2) && cfg && x < H && y < V;
        e_pd = {d2, d1}; e_px = x; e_py = y;
        e_fe = e_pv && x == H - 1 && y == V - 1;
        x = sat(x);
      end
      if (hf) begin
        m_ll = x;
        if (om == 2 && x != 0 && x != H) m_err = 1;
        if (x != 0) y = sat(y);
        x = 0;
      end
      if (vr) begin
        m_fl = y;
        if (om == 2 && y != V) m_err = 1;
        y = 0;
      end
      if (nm != 2) m_err = 0;
      mode = nm;
      vs2 = vs1; vs1 = ov.vsync; hr2 = hr1; hr1 = ov.href; d2 = d1; d1 = ov.data;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("pix_valid", pv, e_pv);
      if (e_pv) begin
        chk("pix_data", pd, e_pd);
        chk("pix_x", px, e_px);
        chk("pix_y", py, e_py);
      end
      chk("frame_start", fs, e_fs);
      chk("frame_end", fe, e_fe);
      chk("capture_on", con, e_con);
      chk("line_len", ll, GEOM ? m_ll : 0);
      chk("frame_lines", fl, GEOM ? m_fl : 0);
      chk("err_geom", err, GEOM ? m_err : 1'b0);
    end
  end

  // strobe log for literal checks
  logic [15:0] got_d[$];
  int          got_x[$], got_y[$];
  bit          got_fe[$];
  int          fs_cnt = 0;
  always @(negedge clk) begin
    if (!rst && pv) begin
      got_d.push_back(pd); got_x.push_back(int'(px)); got_y.push_back(int'(py)); got_fe.push_back(fe);
    end
    if (!rst && fs) fs_cnt++;
  end

  task automatic clear_log();
    got_d.delete(); got_x.delete(); got_y.delete(); got_fe.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pat [16];

  task automatic tick(input bit v, input bit h, input logic [7:0] d);
    @(negedge clk);
    ov.vsync = v; ov.href = h; ov.data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    idle(3);
  endtask

  task automatic line(input int nb, input bit close_vs);
    for (int b = 0; b < nb; b++) tick(1'b0, 1'b1, pat[b]);
    if (close_vs) begin
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      idle(3);
    end else idle(3);
  endtask

  task automatic rand_pat();
    for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pv"}, pv, 0);   chk({tag, "_pd"}, pd, 0);
    chk({tag, "_px"}, px, 0);   chk({tag, "_py"}, py, 0);
    chk({tag, "_fs"}, fs, 0);   chk({tag, "_fe"}, fe, 0);
    chk({tag, "_con"}, con, 0); chk({tag, "_ll"}, ll, 0);
    chk({tag, "_fl"}, fl, 0);   chk({tag, "_err"}, err, 0);
  endtask

  bit hit;

  initial begin
    ov.vsync = 1'b0; ov.href = 1'b0; ov.data = 8'h00;
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0; chk_on = 1'b1;
    idle(3);

    // three frames with SKIP=2: first two discarded, third delivered
    cfg = 1'b1;
    idle(2);
    rand_pat();
    repeat (2) begin vs_pulse(); line(8, 0); line(8, 0); end
    chk("skip_frames_no_pix", got_x.size(), 0);
    chk("skip_frames_no_fs", fs_cnt, 0);
    vs_pulse();
    chk("run_fs_third_rise", fs_cnt, 1);
    pat[0] = 8'hF8; pat[1] = 8'h1F;
    line(8, 0); line(8, 0);
    chk("strobe_count", got_x.size(), 8);
    if (got_d.size() >= 2) begin
      chk("first_data", got_d[0], 16'hF81F);
      chk("first_x", got_x[0], 0);
      chk("first_y", got_y[0], 0);
      chk("second_data", got_d[1], {pat[2], pat[3]});
    end
    for (int i = 0; i < got_x.size(); i++) begin
      chk("coord_x", got_x[i], i % 4);
      chk("coord_y", got_y[i], i / 4);
      chk("frame_end_pos", got_fe[i], i == 7);
    end
    vs_pulse();
    chk("fs_next_frame", fs_cnt, 2);
    chk("frame_lines_2", fl, GEOM ? 2 : 0);
    chk("err_clean_frame", err, 0);

    // odd trailing byte, then an over-long clipped line
    clear_log(); rand_pat();
    line(9, 0);
    chk("odd_line_strobes", got_x.size(), 4);
    chk("odd_line_len", ll, GEOM ? 4 : 0);
    chk("odd_line_err", err, 0);
    line(12, 0);
    chk("long_line_strobes", got_x.size(), 8);
    for (int i = 4; i < got_x.size(); i++) chk("long_line_x", got_x[i], i - 4);
    chk("long_line_len", ll, GEOM ? 6 : 0);
    chk("long_line_err", err, GEOM ? 1 : 0);

    // cfg_done dropped mid-line
    vs_pulse();
    for (int b = 0; b < 3; b++) tick(1'b0, 1'b1, pat[b]);
    cfg = 1'b0;
    tick(1'b0, 1'b1, pat[3]);
    chk("cfg_drop_con", con, 0);
    chk("cfg_drop_pv", pv, 0);
    chk("cfg_drop_err", err, 0);
    for (int b = 4; b < 8; b++) tick(1'b0, 1'b1, pat[b]);
    idle(3);
    cfg = 1'b1; clear_log();
    repeat (SK) begin vs_pulse(); line(8, 0); end
    chk("reskip_no_pix", got_x.size(), 0);
    vs_pulse(); line(8, 0);
    chk("resume_strobes", got_x.size(), 4);

    // randomized frames: variable lines, odd/short lines, coincident vsync, cfg drops
    for (int f = 0; f < 40; f++) begin
      cfg = 1'b1;
      vs_pulse();
      for (int l = 0, nl = $urandom_range(0, 3); l < nl; l++) begin
        if ($urandom_range(0, 14) == 0) cfg = 1'b0;
        rand_pat();
        line($urandom_range(0, 12), (l == nl - 1) && ($urandom_range(0, 3) == 0));
        cfg = 1'b1;
      end
      idle($urandom_range(0, 4));
    end

    // reset mid-line while strobes are active
    cfg = 1'b1; idle(2);
    repeat (SK + 1) begin vs_pulse(); line(8, 0); end
    vs_pulse(); rand_pat();
    hit = 1'b0;
    for (int b = 0; b < 8; b++) begin
      tick(1'b0, 1'b1, pat[b]);
      #6;
      if (pv && !hit) begin
        hit = 1'b1;
        rst = 1'b1;
        #1 chk_zero("midline_reset");
      end
    end
    chk("pv_seen_before_reset", hit, 1);
    @(negedge clk);
    ov.href = 1'b0; ov.vsync = 1'b0;
    #1 rst = 1'b0;
    idle(3);
    chk("after_reset_con", con, 0);
    vs_pulse(); line(8, 0);
    chk("after_reset_skip_con", con, 0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dvp_capture.md
# dvp_capture

Receive-side counterpart of the TFT timing generator: captures the OV5640 DVP stream (vsync/href/8-bit data on the sensor pixel clock), packs byte pairs into RGB565 pixels, and tags each pixel with x/y coordinates and frame markers. It discards the first frames after sensor configuration and clips to the display geometry. It sits between the OV5640 pads and the frame-buffer write path.

## Interface
- H_PIXEL, 800: pixels per delivered line; larger x is clipped.
- V_PIXEL, 480: lines per delivered frame; larger y is clipped.
- SKIP_FRAMES, 10: whole frames discarded after cfg_done before delivery.
- CNT_W, 11: width of coordinate and measurement counters.
- ov5640_pclk  in  1  sensor pixel clock; the only clock.
- sys_rst  in  1  asynchronous, active-high reset.
- cfg_done  in  1  sensor register configuration complete (level).
- ov5640_vsync  in  1  frame sync, active high.
- ov5640_href  in  1  line valid, active high.
- ov5640_data  in  8  DVP data byte.
- pix_valid  out  1  one-cycle strobe, pix_data/pix_x/pix_y valid.
- pix_data  out  16  RGB565 pixel, first byte in [15:8].
- pix_x  out  CNT_W  column of the current pixel.
- pix_y  out  CNT_W  row of the current pixel.
- frame_start  out  1  one-cycle pulse at the start of a delivered frame.
- frame_end  out  1  one-cycle pulse coincident with pixel (H_PIXEL-1, V_PIXEL-1).
- capture_on  out  1  high while in RUN.
- line_len  out  CNT_W  pixel count of the last completed line.
- frame_lines  out  CNT_W  line count of the last completed frame.
- err_geom  out  1  sticky geometry mismatch flag.

## Operation
- Input stage: vsync, href and data registered once (v_d, h_d, d_d). Edges are detected on these registered copies.
- FSM states are WAIT_CFG, SKIP and RUN. Reset state is WAIT_CFG.
  - WAIT_CFG -> SKIP on a v_d rising edge while cfg_done=1. The skip count starts at 0.
  - If SKIP_FRAMES=0, WAIT_CFG goes directly to RUN at that edge.
  - SKIP: each v_d rise increments the skip count. At the rise where the count reaches SKIP_FRAMES, the FSM enters RUN.
  - Any state -> WAIT_CFG on the cycle after cfg_done is sampled low. pix_valid is suppressed from that cycle on, and the skip sequence restarts.
- Byte packing:
  - A phase bit toggles on each cycle with h_d=1 and is cleared while h_d=0.
  - Phase 0 byte is latched as the high byte. The phase 1 byte completes the pixel.
  - A trailing odd byte in a line is dropped.
- Counters:
  - x_cnt increments per completed pixel and clears on the h_d falling edge.
  - y_cnt increments on the h_d falling edge if the line produced at least 1 pixel, and clears on the v_d rise.
  - Counters run in every state; only the outputs are gated.
- pix_valid=1 only in RUN with x_cnt<H_PIXEL and y_cnt<V_PIXEL. Clipped pixels are still counted.
- frame_start pulses on each v_d rise while in RUN, including the rise that enters RUN.
- Width rule: counters saturate at 2^CNT_W-1 and do not wrap.
- Reset: all outputs are 0, counters are 0, and the FSM is in WAIT_CFG.

## Timing
- Latency: the second byte of a pixel present at the pins before edge n is registered at edge n. pix_valid, pix_data, pix_x and pix_y are registered at edge n+1 and held for one cycle.
- frame_start registers 2 edges after vsync rises at the pins.
- There is no backpressure. The consumer must accept every strobe.
- Simultaneous v_d rise and h_d fall: the line closes first (line_len and y_cnt update), then the y clear is applied in the same cycle; the y clear wins.
- An href falling mid-pixel (phase 1 pending) discards the half pixel.

## Configuration
- GEOM_CHECK_EN defined:
  - line_len latches x_cnt at each h_d fall.
  - frame_lines latches y_cnt at each v_d rise.
  - err_geom sets in RUN if line_len≠H_PIXEL at any h_d fall (lines with 0 pixels excluded), or if frame_lines≠V_PIXEL at a v_d rise ending a RUN frame.
  - err_geom clears on reset or on leaving RUN.
- GEOM_CHECK_EN not defined: line_len, frame_lines and err_geom are tied to 0. The ports are retained.

## Structure
- Shared package dvp_pkg holds the FSM state enum, default H_PIXEL/V_PIXEL/SKIP_FRAMES and CNT_W.
- One sub-module, dvp_byte_pack, contains the input registers, phase bit and 16-bit assembly. It outputs pix_done and pix_word. The FSM, counters and geometry check stay in the top level.

## Test plan
- Reset mid-line with pix_valid active: every output reads 0 within the reset assertion, and the FSM is in WAIT_CFG after release.
- SKIP_FRAMES=2, cfg_done=1, three frames sent:
  - No pix_valid in frames 1–2.
  - frame_start at the third vsync rise.
  - Bytes 0xF8,0x1F -> pix_data=0xF81F, pix_x=0, pix_y=0.
- H_PIXEL=4, V_PIXEL=2, SKIP_FRAMES=0, 2 lines of 8 bytes:
  - Strobes appear at (0,0)..(3,0) then (0,1)..(3,1).
  - frame_end coincides with (3,1).
  - frame_lines=2 at the next vsync, err_geom=0.
- 9-byte line with H_PIXEL=4: 4 strobes, odd byte dropped, line_len=4. Repeat with H_PIXEL=5: err_geom=1 after href falls.
- 12-byte line with H_PIXEL=4: strobes only for x=0..3, and line_len=6 (GEOM_CHECK_EN).
- cfg_done dropped mid-frame: pix_valid=0 from the next cycle and capture_on=0. After cfg_done is reasserted, SKIP_FRAMES frames pass before delivery resumes.
